next_pc_unit: RTL and testbench

NEXT_PC_UNIT -- requirements
Module: next_pc

---
 rtl/next_pc_unit.sv | 41 ++++
 tb/tb_next_pc_unit.sv | 95 +++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// next_pc_unit: fetch-stage next-PC prediction (J/JAL target, else PC+4, branches predicted
// not-taken) with opcode decode flags and a registered copy of the predicted PC.
module next_pc_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_valP,
    input  logic [5:0]  f_op,
    input  logic [31:0] f_valC,
    output logic [31:0] f_valP,
    output logic        f_jump,
    output logic        f_bad_op,
    output logic [31:0] f_valP_q
);
    localparam logic [5:0] IROP  = 6'b000000;
    localparam logic [5:0] IJ    = 6'b000010;
    localparam logic [5:0] IJAL  = 6'b000011;
    localparam logic [5:0] IBEQ  = 6'b000100;
    localparam logic [5:0] IBNE  = 6'b000101;
    localparam logic [5:0] IADDI = 6'b001000;
    localparam logic [5:0] ISLTI = 6'b001010;
    localparam logic [5:0] IANDI = 6'b001100;
    localparam logic [5:0] IORI  = 6'b001101;
    localparam logic [5:0] ILW   = 6'b100011;
    localparam logic [5:0] ISW   = 6'b101011;

    logic [31:0] f_valP_d;

    // f_bad_op is informational only; unknown opcodes still fall through to PC+4
    always_comb begin
        f_jump   = (f_op == IJ) || (f_op == IJAL);
        f_bad_op = !((f_op == IROP)  || (f_op == IJ)    || (f_op == IJAL)  || (f_op == IBEQ) ||
                     (f_op == IBNE)  || (f_op == IADDI) || (f_op == ISLTI) || (f_op == IANDI) ||
                     (f_op == IORI)  || (f_op == ILW)   || (f_op == ISW));
        f_valP   = f_jump ? f_valC : F_valP + 32'd4;
        f_valP_d = f_valP;
    end

    always_ff @(posedge clk) begin
        f_valP_q <= reset ? 32'd0 : f_valP_d;
    end
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed spec vectors plus randomized stimulus against a behavioural
// next-PC model; checks the combinational outputs and the registered PC every cycle.
module tb_next_pc_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] F_valP;
    logic [5:0]  f_op;
    logic [31:0] f_valC;
    logic [31:0] f_valP;
    logic        f_jump;
    logic        f_bad_op;
    logic [31:0] f_valP_q;
    int checks = 0;
    int errors = 0;
    int valid_ops[11] = '{0, 2, 3, 4, 5, 8, 10, 12, 13, 35, 43};

    next_pc_unit dut (
        .clk(clk),
        .reset(reset),
        .F_valP(F_valP),
        .f_op(f_op),
        .f_valC(f_valC),
        .f_valP(f_valP),
        .f_jump(f_jump),
        .f_bad_op(f_bad_op),
        .f_valP_q(f_valP_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_known(input int op);
        foreach (valid_ops[i]) if (valid_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_jump(input int op);
        return op == 2 || op == 3;
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input int op, input logic [31:0] c);
        return is_jump(op) ? c : 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
    endfunction

    // Apply one cycle: check combinational outputs, then the register after the edge.
    task automatic step(input string tag, input bit r, input logic [31:0] pc, input int op,
                        input logic [31:0] c);
        logic [31:0] exp_q;
        reset  = r;
        F_valP = pc;
        f_op   = 6'(op);
        f_valC = c;
        #1;
        check({tag, ".valP"}, f_valP, next_pc(pc, op, c));
        check({tag, ".jump"}, 32'(f_jump), 32'(is_jump(op)));
        check({tag, ".bad"}, 32'(f_bad_op), 32'(!is_known(op)));
        exp_q = r ? 32'd0 : next_pc(pc, op, c);
        @(posedge clk);
        #1;
        check({tag, ".q"}, f_valP_q, exp_q);
    endtask

    initial begin
        step("rst", 1, 0, 0, 0);
        step("irop", 0, 0, 0, 0);
        step("ij", 0, 4, 2, 88);
        step("ijal", 0, 4, 3, 88);
        step("isw", 0, 88, 43, 0);
        step("iaddi", 0, 92, 8, 0);
        step("iori", 0, 96, 13, 4);
        step("iandi", 0, 100, 12, 8);
        step("islti", 0, 104, 10, 16);
        step("wrap", 0, 32'hFFFF_FFFC, 35, 32'h1234);
        step("ibeq", 0, 32'h10, 4, 32'h100);
        step("ibne", 0, 32'h3, 5, 32'h100);
        step("badop", 0, 32'h20, 63, 32'h40);
        step("jodd", 0, 32'h20, 2, 32'h8000_0003);
        step("rst_mid", 1, 4, 2, 88);
        step("resume", 0, 4, 2, 88);
        for (int i = 0; i < 400; i++) begin
            int op;
            op = ($urandom_range(1) == 1) ? valid_ops[$urandom_range(10)] : int'($urandom_range(63));
            step("rand", $urandom_range(9) == 0, $urandom, op, $urandom);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
